// File: rtl/data_mem_lsu.sv
// data_mem_lsu: load/store initiator for the dual-port data_mem.
// Byte accesses use 8-bit port A, word accesses use 32-bit port B. Memory-side outputs are
// registered; load responses come back in request order through an RD_LAT-deep tag pipeline.
// Optional feature macro: DATA_MEM_LSU_UNALIGNED_EN -- when defined, unaligned word loads are
// split into two word reads and merged; when undefined they are rejected with rsp_err.

module data_mem_lsu #(
  parameter int unsigned RD_LAT = 2
) (
  input  logic        clock,
  input  logic        reset_n,
  // core request
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic        req_size,
  input  logic [15:0] req_addr,
  input  logic [31:0] req_wdata,
  // core response
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  // data_mem port A (byte)
  output logic [15:0] address_a,
  output logic [7:0]  data_a,
  output logic        wren_a,
  input  logic [7:0]  q_a,
  // data_mem port B (word)
  output logic [13:0] address_b,
  output logic [31:0] data_b,
  output logic        wren_b,
  input  logic [31:0] q_b
);

  // PhFirst marks the low half of a split load: it is captured, not returned.
  typedef enum logic [1:0] {
    PhNone   = 2'd0,
    PhFirst  = 2'd1,
    PhSecond = 2'd2
  } phase_e;

  typedef struct packed {
    logic       valid;
    logic       err;
    logic       size;
    logic [1:0] offset;
    phase_e     phase;
  } tag_t;

  logic        accept;

  logic [15:0] address_a_d;
  logic [7:0]  data_a_d;
  logic        wren_a_d;
  logic [13:0] address_b_d;
  logic [31:0] data_b_d;
  logic        wren_b_d;

  tag_t        issue_tag_d;
  tag_t        issue_tag_q;
  tag_t        pipe_q [RD_LAT];
  tag_t        tag_out;

`ifdef DATA_MEM_LSU_UNALIGNED_EN
  typedef enum logic {
    StIdle   = 1'b0,
    StSplit2 = 1'b1
  } state_e;

  state_e      state_d;
  state_e      state_q;
  logic [13:0] split_idx_d;
  logic [13:0] split_idx_q;
  logic [1:0]  split_off_d;
  logic [1:0]  split_off_q;
  logic [31:0] split_word_q;

  assign req_ready = reset_n && (state_q == StIdle);
`else
  assign req_ready = reset_n;
`endif

  assign accept  = req_valid && req_ready;
  assign tag_out = pipe_q[RD_LAT-1];

  // Decode the accepted request (or the pending split half) into next memory-port values.
  always_comb begin
    address_a_d = address_a;
    data_a_d    = data_a;
    wren_a_d    = 1'b0;
    address_b_d = address_b;
    data_b_d    = data_b;
    wren_b_d    = 1'b0;
    issue_tag_d = '0;
`ifdef DATA_MEM_LSU_UNALIGNED_EN
    state_d     = state_q;
    split_idx_d = split_idx_q;
    split_off_d = split_off_q;

    if (state_q == StSplit2) begin
      address_b_d        = split_idx_q;
      issue_tag_d.valid  = 1'b1;
      issue_tag_d.size   = 1'b1;
      issue_tag_d.offset = split_off_q;
      issue_tag_d.phase  = PhSecond;
      state_d            = StIdle;
    end else
`endif
    if (accept) begin
      if (!req_size) begin
        address_a_d = req_addr;
        if (req_we) begin
          wren_a_d = 1'b1;
          data_a_d = req_wdata[7:0];
        end else begin
          issue_tag_d.valid  = 1'b1;
          issue_tag_d.offset = req_addr[1:0];
        end
      end else if (req_addr[1:0] == 2'b00) begin
        address_b_d = req_addr[15:2];
        if (req_we) begin
          wren_b_d = 1'b1;
          data_b_d = req_wdata;
        end else begin
          issue_tag_d.valid = 1'b1;
          issue_tag_d.size  = 1'b1;
        end
      end else if (req_we) begin
        // Unaligned word store: no write, just an in-order error response.
        issue_tag_d.valid  = 1'b1;
        issue_tag_d.err    = 1'b1;
        issue_tag_d.size   = 1'b1;
        issue_tag_d.offset = req_addr[1:0];
      end else begin
`ifdef DATA_MEM_LSU_UNALIGNED_EN
        address_b_d        = req_addr[15:2];
        issue_tag_d.valid  = 1'b1;
        issue_tag_d.size   = 1'b1;
        issue_tag_d.offset = req_addr[1:0];
        issue_tag_d.phase  = PhFirst;
        split_idx_d        = req_addr[15:2] + 14'd1;  // wraps 0x3FFF -> 0x0000
        split_off_d        = req_addr[1:0];
        state_d            = StSplit2;
`else
        issue_tag_d.valid  = 1'b1;
        issue_tag_d.err    = 1'b1;
        issue_tag_d.size   = 1'b1;
        issue_tag_d.offset = req_addr[1:0];
`endif
      end
    end
  end

  // Register the memory-port outputs and the issue-stage tag.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      address_a   <= '0;
      data_a      <= '0;
      wren_a      <= 1'b0;
      address_b   <= '0;
      data_b      <= '0;
      wren_b      <= 1'b0;
      issue_tag_q <= '0;
    end else begin
      address_a   <= address_a_d;
      data_a      <= data_a_d;
      wren_a      <= wren_a_d;
      address_b   <= address_b_d;
      data_b      <= data_b_d;
      wren_b      <= wren_b_d;
      issue_tag_q <= issue_tag_d;
    end
  end

  // Tag shift register: the tag leaves the last stage when the memory's q_* is valid for it.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < RD_LAT; i++) begin
        pipe_q[i] <= '0;
      end
    end else begin
      pipe_q[0] <= issue_tag_q;
      for (int unsigned i = 1; i < RD_LAT; i++) begin
        pipe_q[i] <= pipe_q[i-1];
      end
    end
  end

`ifdef DATA_MEM_LSU_UNALIGNED_EN
  // Split FSM state and the saved second-half word index / byte offset.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      split_idx_q <= '0;
      split_off_q <= '0;
    end else begin
      state_q     <= state_d;
      split_idx_q <= split_idx_d;
      split_off_q <= split_off_d;
    end
  end

  // Hold the first word of a split load until the second word arrives.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      split_word_q <= '0;
    end else if (tag_out.valid && (tag_out.phase == PhFirst)) begin
      split_word_q <= q_b;
    end
  end
`else
  logic unused_tag_offset;
  assign unused_tag_offset = ^tag_out.offset;
`endif

  // Build the response from the emerging tag and the memory read data.
  always_comb begin
    rsp_valid = tag_out.valid && (tag_out.phase != PhFirst);
    rsp_err   = tag_out.valid && tag_out.err;
    rsp_rdata = '0;
    if (rsp_valid && !tag_out.err) begin
      if (!tag_out.size) begin
        rsp_rdata = {24'h000000, q_a};
      end else begin
        rsp_rdata = q_b;
`ifdef DATA_MEM_LSU_UNALIGNED_EN
        if (tag_out.phase == PhSecond) begin
          // {second, first} >> 8*offset, low 32 bits.
          unique case (tag_out.offset)
            2'd1:    rsp_rdata = {q_b[7:0],  split_word_q[31:8]};
            2'd2:    rsp_rdata = {q_b[15:0], split_word_q[31:16]};
            2'd3:    rsp_rdata = {q_b[23:0], split_word_q[31:24]};
            default: rsp_rdata = q_b;
          endcase
        end
`endif
      end
    end
  end

endmodule
